// File: rtl/uart_rx_conditioner.sv
// uart_rx_conditioner: synchronises, deglitches and break-detects the UART RX pin.
// Define UART_RX_BREAK_EN to build the break FSM; otherwise break_det/break_pulse are tied low.
module uart_rx_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int BREAK_CYCLES  = 4096,
    parameter int BREAK_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_pin,
    output logic       rxd_out,
    output logic       break_det,
    output logic       break_pulse,
    output logic [7:0] glitch_cnt
);
    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [FCW-1:0]         filt_cnt_q;
    logic [7:0]             glitch_q;
    logic                   s;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rxd_out    = filt_q;
    assign glitch_cnt = glitch_q;

    // A level that dies before reaching FILTER_CYCLES is counted as a rejected glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            glitch_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_pin};
            if (s == filt_q) begin
                filt_cnt_q <= '0;
                if (filt_cnt_q != '0 && glitch_q != 8'hff) glitch_q <= glitch_q + 8'd1;
            end else if (filt_cnt_q == FCW'(FILTER_CYCLES - 1)) begin
                filt_q     <= s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FCW'(1);
            end
        end
    end

`ifdef UART_RX_BREAK_EN
    typedef enum logic [1:0] {IDLE, LOW_COUNT, BREAK} state_t;

    state_t             state_q, state_d;
    logic [BREAK_W-1:0] bcnt_q, bcnt_d;
    logic               break_det_q, break_pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bcnt_q        <= '0;
            break_det_q   <= 1'b0;
            break_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            break_det_q   <= state_d == BREAK;
            break_pulse_q <= state_q == LOW_COUNT && state_d == BREAK;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: if (!filt_q) begin
                state_d = LOW_COUNT;
                bcnt_d  = BREAK_W'(1);
            end
            LOW_COUNT: if (filt_q) begin
                state_d = IDLE;
                bcnt_d  = '0;
            end else if (bcnt_q == BREAK_W'(BREAK_CYCLES - 1)) begin
                state_d = BREAK;
            end else begin
                bcnt_d = bcnt_q + BREAK_W'(1);
            end
            BREAK: if (filt_q) begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase
    end

    assign break_det   = break_det_q;
    assign break_pulse = break_pulse_q;
`else
    logic unused_brk;

    assign unused_brk  = BREAK_CYCLES > BREAK_W;
    assign break_det   = 1'b0;
    assign break_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_conditioner.sv
// tb_uart_rx_conditioner: directed checks of latency, glitch counting, break detection and reset.
module tb_uart_rx_conditioner;
`ifdef UART_RX_BREAK_EN
    localparam int BRK = 1;
`else
    localparam int BRK = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, rxd_pin;
    logic       rxd_out, break_det, break_pulse;
    logic [7:0] glitch_cnt;
    int         errors = 0;
    int         checks = 0;
    int         npulse, first;
    bit         saw_low;

    uart_rx_conditioner dut (
        .clk        (clk),
        .reset      (reset),
        .rxd_pin    (rxd_pin),
        .rxd_out    (rxd_out),
        .break_det  (break_det),
        .break_pulse(break_pulse),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch(input int lowc, input int highc, output bit low_seen);
        low_seen = 0;
        rxd_pin = 1'b0;
        repeat (lowc) begin
            @(negedge clk);
            low_seen |= !rxd_out;
        end
        rxd_pin = 1'b1;
        repeat (highc) begin
            @(negedge clk);
            low_seen |= !rxd_out;
        end
    endtask

    task automatic run_low(input int n);
        npulse = 0;
        first  = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (break_pulse) begin
                npulse++;
                if (first == 0) first = k;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        rxd_pin = 1'b1;
        @(negedge clk);
        step(2);
        chk("reset_rxd_out", rxd_out, 1);
        chk("reset_glitch", glitch_cnt, 0);
        chk("reset_break_det", break_det, 0);
        chk("reset_break_pulse", break_pulse, 0);

        reset = 1'b0;
        step(20);
        chk("idle_rxd_out", rxd_out, 1);
        chk("idle_glitch", glitch_cnt, 0);
        chk("idle_break_det", break_det, 0);

        rxd_pin = 1'b0;
        step(5);
        chk("fall_edge5", rxd_out, 1);
        step(1);
        chk("fall_edge6", rxd_out, 0);
        rxd_pin = 1'b1;
        step(5);
        chk("rise_edge5", rxd_out, 0);
        step(1);
        chk("rise_edge6", rxd_out, 1);
        chk("clean_edges_glitch", glitch_cnt, 0);
        step(4);

        glitch(3, 3, saw_low);
        chk("glitch1_rxd_low", saw_low, 0);
        chk("glitch1_cnt", glitch_cnt, 1);

        glitch(4, 10, saw_low);
        chk("pulse4_passes", saw_low, 1);
        chk("pulse4_not_counted", glitch_cnt, 1);

        saw_low = 0;
        for (int i = 0; i < 253; i++) begin
            bit sl;
            glitch(3, 3, sl);
            saw_low |= sl;
        end
        chk("glitch254_cnt", glitch_cnt, 254);
        glitch(3, 3, saw_low);
        chk("glitch255_cnt", glitch_cnt, 255);
        for (int i = 0; i < 45; i++) begin
            bit sl;
            glitch(3, 3, sl);
            saw_low |= sl;
        end
        chk("glitch_saturate", glitch_cnt, 255);
        chk("glitch_rxd_never_low", saw_low, 0);
        step(5);

        rxd_pin = 1'b0;
        run_low(5000);
        chk("break_first_pulse", first, BRK ? 4102 : 0);
        chk("break_pulse_count", npulse, BRK);
        chk("break_det_held", break_det, BRK);
        chk("break_rxd_raw_low", rxd_out, 0);
        rxd_pin = 1'b1;
        step(6);
        chk("break_exit_rxd", rxd_out, 1);
        chk("break_exit_det_pre", break_det, BRK);
        step(1);
        chk("break_exit_det", break_det, 0);
        step(5);

        rxd_pin = 1'b0;
        run_low(4095);
        chk("short_low_pulses", npulse, 0);
        rxd_pin = 1'b1;
        run_low(10);
        chk("short_low_tail_pulses", npulse, 0);
        chk("short_low_det", break_det, 0);
        chk("short_low_rxd", rxd_out, 1);

        rxd_pin = 1'b0;
        step(4200);
        chk("pre_reset_det", break_det, BRK);
        chk("pre_reset_glitch", glitch_cnt, 255);
        reset = 1'b1;
        step(1);
        chk("midreset_rxd", rxd_out, 1);
        chk("midreset_det", break_det, 0);
        chk("midreset_pulse", break_pulse, 0);
        chk("midreset_glitch", glitch_cnt, 0);
        reset = 1'b0;
        run_low(4200);
        chk("rebreak_first_pulse", first, BRK ? 4102 : 0);
        chk("rebreak_pulse_count", npulse, BRK);
        chk("rebreak_det", break_det, BRK);
        chk("rebreak_glitch", glitch_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
